// File: rtl/chip8_pkg.sv
// chip8_pkg: shared widths, memory map constants and arbiter state type
package chip8_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] PROTECT_TOP_DEF = 12'h1FF;
  localparam logic [ADDR_W-1:0] FONT_BASE = 12'h050;
  localparam logic [ADDR_W-1:0] PROG_BASE = 12'h200;
  localparam int PORT_LOAD = 0;
  localparam int PORT_CPU = 1;
  localparam int PORT_DRAW = 2;
  typedef enum logic {IDLE, OWNED} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder
//   req   : per-port requests
//   ptr   : port with highest priority this cycle
//   gnt   : one-hot winner
//   idx   : winner index
//   valid : any request present
module rr_pick
  import chip8_pkg::*;
#(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);
  always_comb begin
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = PW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the single-port CHIP-8 memory
//   req/we/lock/addr/wdata : per-port request bundle, port i at slice i
//   gnt         : one-hot access accepted this cycle
//   rvalid      : one-hot, rdata holds that port's read result
//   rdata       : shared read data bus
//   prot_err    : pulse, a write into the protected region was dropped
//   burst_err   : pulse, a lock was force-released at MAX_BURST
//   mem_*       : drive to / data from the memory block
module mem_arbiter
  import chip8_pkg::*;
#(
  parameter int NREQ = 3,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = PROTECT_TOP_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     prot_err,
  output logic                     burst_err,
  output logic                     mem_set,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t state, state_n;
  logic [PW-1:0] owner, owner_n, ptr, ptr_n, rr_idx, w;
  logic [CW-1:0] cnt, cnt_n, cnt_nx;
  logic [NREQ-1:0] rr_gnt, win;
  logic rr_valid, hold, valid, w_we, w_lock, blocked, burst_end;
  logic [ADDR_W-1:0] w_addr, last_addr;
  logic [DATA_W-1:0] w_data, last_data;
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(rr_gnt),
    .idx(rr_idx),
    .valid(rr_valid)
  );
  // An owner that still requests wins outright; otherwise plain round-robin.
  always_comb begin
    hold = (state == OWNED) && req[owner];
    w = hold ? owner : rr_idx;
    valid = hold | rr_valid;
    win = hold ? NREQ'(1) << owner : rr_gnt;
    w_addr = addr[ADDR_W*int'(w) +: ADDR_W];
    w_data = wdata[DATA_W*int'(w) +: DATA_W];
    w_we = we[w];
    w_lock = lock[w];
    blocked = (NREQ > 1) && (w != '0) && (w_addr <= PROTECT_TOP);
    cnt_nx = hold ? cnt + CW'(1) : CW'(1);
    burst_end = valid && w_lock && (cnt_nx >= CW'(MAX_BURST));
    state_n = (valid && w_lock && !burst_end) ? OWNED : IDLE;
    owner_n = valid ? w : owner;
    cnt_n = (state_n == OWNED) ? cnt_nx : '0;
    ptr_n = !valid ? ptr : (w == PW'(NREQ - 1)) ? '0 : w + PW'(1);
    gnt = rst_n ? win : '0;
    mem_set = rst_n && valid && w_we && !blocked;
    mem_address = !rst_n ? '0 : valid ? w_addr : last_addr;
    mem_data_in = !rst_n ? '0 : valid ? w_data : last_data;
    rdata = mem_data_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
      rvalid <= '0;
      prot_err <= 1'b0;
      burst_err <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      rvalid <= (valid && !w_we) ? win : '0;
      prot_err <= valid && w_we && blocked;
      burst_err <= burst_end;
      if (valid) begin
        last_addr <= w_addr;
        last_data <= w_data;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
  import chip8_pkg::*;
  typedef struct {
    int port;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  logic [2:0] req = '0, we_a = '0, lock_a = '0;
  logic [11:0] addr_a [3];
  logic [7:0] wdata_a [3];
  logic [35:0] addr_bus;
  logic [23:0] wdata_bus;
  logic [2:0] gnt, rvalid;
  logic [7:0] rdata, mem_data_in, mem_data_out;
  logic prot_err, burst_err, mem_set;
  logic [11:0] mem_address;
  logic [7:0] mem [4096];
  logic [7:0] ref_mem [4096];
  exp_t exp_q [$];
  int total = 0;
  int bad = 0;
  assign addr_bus = {addr_a[2], addr_a[1], addr_a[0]};
  assign wdata_bus = {wdata_a[2], wdata_a[1], wdata_a[0]};
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we_a), .lock(lock_a),
    .addr(addr_bus), .wdata(wdata_bus), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .prot_err(prot_err), .burst_err(burst_err),
    .mem_set(mem_set), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );
  function automatic logic [7:0] init_val(int a);
    logic [11:0] x;
    x = 12'(a);
    if (x >= FONT_BASE && x < FONT_BASE + 12'd5)
      return (x == FONT_BASE || x == FONT_BASE + 12'd4) ? 8'hF0 : 8'h90;
    return x[7:0] ^ 8'h5A;
  endfunction
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_set) mem[mem_address] <= mem_data_in;
      mem_data_out <= mem[mem_address];
    end
  end
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    end else if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (rvalid !== (3'b1 << e.port) || rdata !== e.data) begin
          bad++;
          $display("FAIL sb_read port%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                   e.port, rvalid, rdata, 3'b1 << e.port, e.data);
        end
      end else begin
        total++;
        if (rvalid !== 3'b000) begin
          bad++;
          $display("FAIL sb_idle got rvalid=%b want 000", rvalid);
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (gnt[p]) begin
          if (!we_a[p]) exp_q.push_back('{p, ref_mem[addr_a[p]]});
          else if (p == PORT_LOAD || addr_a[p] > 12'h1FF) ref_mem[addr_a[p]] = wdata_a[p];
        end
      end
    end
  end
  task automatic clr();
    req = '0;
    we_a = '0;
    lock_a = '0;
  endtask
  task automatic put(int p, bit w, logic [11:0] a, logic [7:0] d, bit l);
    req[p] = 1'b1;
    we_a[p] = w;
    lock_a[p] = l;
    addr_a[p] = a;
    wdata_a[p] = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b111;
    we_a = 3'b111;
    for (int p = 0; p < 3; p++) begin
      addr_a[p] = 12'h7A0;
      wdata_a[p] = 8'h3C;
    end
    #3;
    total++;
    if (gnt !== 3'b000 || mem_set !== 1'b0 || mem_address !== 12'h000 || mem_data_in !== 8'h00) begin
      bad++;
      $display("FAIL reset_drive got gnt=%b set=%b addr=%h din=%h want 000 0 000 00",
               gnt, mem_set, mem_address, mem_data_in);
    end
    total++;
    if (rvalid !== 3'b000 || prot_err !== 1'b0 || burst_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs got rvalid=%b prot=%b burst=%b want 000 0 0", rvalid, prot_err, burst_err);
    end
    do_reset();
  endtask
  task automatic test_single_read();
    do_reset();
    step();
    put(PORT_CPU, 1'b0, FONT_BASE, 8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (gnt !== 3'b010 || mem_address !== FONT_BASE || mem_set !== 1'b0) begin
      bad++;
      $display("FAIL single_gnt got gnt=%b addr=%h set=%b want 010 050 0", gnt, mem_address, mem_set);
    end
    step();
    clr();
    @(negedge clk);
    total++;
    if (rvalid !== 3'b010 || rdata !== 8'hF0) begin
      bad++;
      $display("FAIL single_rdata got rvalid=%b rdata=%h want 010 f0", rvalid, rdata);
    end
    total++;
    if (gnt !== 3'b000 || mem_address !== FONT_BASE) begin
      bad++;
      $display("FAIL single_hold got gnt=%b addr=%h want 000 050", gnt, mem_address);
    end
  endtask
  task automatic test_round_robin();
    logic [2:0] want;
    do_reset();
    step();
    for (int p = 0; p < 3; p++) put(p, 1'b0, 12'h400 + 12'(p), 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      @(negedge clk);
      want = 3'b001 << (k % 3);
      total++;
      if (gnt !== want) begin
        bad++;
        $display("FAIL rr_order cycle%0d got gnt=%b want %b", k, gnt, want);
      end
    end
    step();
    clr();
    @(negedge clk);
  endtask
  task automatic test_locked_burst();
    logic [2:0] want;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      clr();
      if (k < 5) put(PORT_DRAW, 1'b0, 12'h300 + 12'(k), 8'h00, k < 4);
      if (k >= 1) put(PORT_CPU, 1'b0, FONT_BASE + 12'd1, 8'h00, 1'b0);
      @(negedge clk);
      want = (k < 5) ? 3'b100 : 3'b010;
      total++;
      if (gnt !== want) begin
        bad++;
        $display("FAIL burst_gnt cycle%0d got gnt=%b want %b", k, gnt, want);
      end
      if (k >= 1) begin
        total++;
        if (rvalid !== 3'b100) begin
          bad++;
          $display("FAIL burst_rvalid cycle%0d got rvalid=%b want 100", k, rvalid);
        end
      end
    end
    step();
    clr();
    @(negedge clk);
  endtask
  task automatic test_protection();
    do_reset();
    step();
    put(PORT_CPU, 1'b1, 12'h100, 8'hAA, 1'b0);
    @(negedge clk);
    total++;
    if (gnt !== 3'b010 || mem_set !== 1'b0) begin
      bad++;
      $display("FAIL prot_block got gnt=%b set=%b want 010 0", gnt, mem_set);
    end
    step();
    clr();
    @(negedge clk);
    total++;
    if (prot_err !== 1'b1) begin
      bad++;
      $display("FAIL prot_pulse got %b want 1", prot_err);
    end
    step();
    put(PORT_LOAD, 1'b0, 12'h100, 8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (prot_err !== 1'b0 || gnt !== 3'b001) begin
      bad++;
      $display("FAIL prot_clear got prot=%b gnt=%b want 0 001", prot_err, gnt);
    end
    step();
    put(PORT_LOAD, 1'b1, 12'h100, 8'hAA, 1'b0);
    @(negedge clk);
    total++;
    if (rdata !== 8'h5A || mem_set !== 1'b1) begin
      bad++;
      $display("FAIL prot_orig got rdata=%h set=%b want 5a 1", rdata, mem_set);
    end
    step();
    put(PORT_LOAD, 1'b0, 12'h100, 8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (prot_err !== 1'b0) begin
      bad++;
      $display("FAIL prot_loader got prot=%b want 0", prot_err);
    end
    step();
    clr();
    put(PORT_CPU, 1'b1, 12'h1FF, 8'h33, 1'b0);
    @(negedge clk);
    total++;
    if (rdata !== 8'hAA || mem_set !== 1'b0) begin
      bad++;
      $display("FAIL prot_edge got rdata=%h set=%b want aa 0", rdata, mem_set);
    end
    step();
    put(PORT_CPU, 1'b1, PROG_BASE, 8'h44, 1'b0);
    @(negedge clk);
    total++;
    if (mem_set !== 1'b1 || prot_err !== 1'b1) begin
      bad++;
      $display("FAIL prot_prog got set=%b prot=%b want 1 1", mem_set, prot_err);
    end
    step();
    put(PORT_CPU, 1'b0, PROG_BASE, 8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (prot_err !== 1'b0) begin
      bad++;
      $display("FAIL prot_prog_clear got prot=%b want 0", prot_err);
    end
    step();
    clr();
    @(negedge clk);
  endtask
  task automatic test_burst_limit();
    logic [2:0] want;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step();
      clr();
      put(PORT_CPU, 1'b0, 12'h400 + 12'(k), 8'h00, 1'b1);
      if (k >= 1) put(PORT_DRAW, 1'b0, 12'h500, 8'h00, 1'b0);
      @(negedge clk);
      want = (k < 16) ? 3'b010 : 3'b100;
      total++;
      if (gnt !== want || burst_err !== (k == 16)) begin
        bad++;
        $display("FAIL limit cycle%0d got gnt=%b burst=%b want %b %b", k, gnt, burst_err, want, k == 16);
      end
    end
    step();
    clr();
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step();
      put(PORT_DRAW, 1'b0, 12'h300 + 12'(k), 8'h00, 1'b1);
      @(negedge clk);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 3'b000 || mem_set !== 1'b0 || rvalid !== 3'b000) begin
      bad++;
      $display("FAIL areset_now got gnt=%b set=%b rvalid=%b want 000 0 000", gnt, mem_set, rvalid);
    end
    @(negedge clk);
    #2;
    clr();
    rst_n = 1'b1;
    step();
    put(PORT_CPU, 1'b0, 12'h600, 8'h00, 1'b0);
    put(PORT_DRAW, 1'b0, 12'h601, 8'h00, 1'b0);
    @(negedge clk);
    total++;
    if (gnt !== 3'b010 || rvalid !== 3'b000) begin
      bad++;
      $display("FAIL areset_after got gnt=%b rvalid=%b want 010 000", gnt, rvalid);
    end
    step();
    clr();
    @(negedge clk);
  endtask
  initial begin
    for (int p = 0; p < 3; p++) begin
      addr_a[p] = '0;
      wdata_a[p] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    #1 preload = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_burst();
    test_protection();
    test_burst_limit();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
